// File: rtl/scratchpad_block_reader.sv
// Block reader for the per-core scratchpad: reads word_count words upward from
// base_addr through a 1-cycle-latency Avalon-MM port and streams them out in
// address order, keeping a running 32-bit additive checksum of emitted words.
//
// Stream handshake: a word transfers in every cycle where out_valid and
// out_ready are both high; once out_valid rises it stays high with out_data
// unchanged until that transfer happens (only abort or reset can withdraw it).
module scratchpad_block_reader #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int BUF_D  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum,
  output logic [ADDR_W-1:0] sp_address,
  output logic              sp_chipselect,
  output logic              sp_write,
  output logic [3:0]        sp_byteenable,
  output logic [DATA_W-1:0] sp_writedata,
  output logic              sp_clken,
  input  logic [DATA_W-1:0] sp_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = (BUF_D > 2) ? $clog2(BUF_D) : 1;
  localparam int CNT_W = $clog2(BUF_D + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W:0]    rem_q, rem_d;
  logic [DATA_W-1:0]  csum_q, csum_d;
  logic               inflight_q, inflight_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]  buf_q [BUF_D];

  logic buf_empty, xfer, push, pop, issue;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stream view: an empty buffer passes the returning read straight through,
  // which is what gives the 2-cycle start-to-valid latency.
  always_comb begin
    buf_empty = (cnt_q == '0);
    out_valid = !abort && (!buf_empty || inflight_q);
    out_data  = '0;
    if (out_valid) out_data = buf_empty ? sp_readdata : buf_q[rd_ptr_q];
    xfer  = out_valid && out_ready;
    pop   = xfer && !buf_empty;
    push  = !abort && inflight_q && !(buf_empty && out_ready);
    issue = (state_q == S_RUN) && !abort && ((int'(cnt_q) + int'(inflight_q)) < BUF_D);
  end

  // Skid-buffer bookkeeping; abort empties it outright.
  always_comb begin
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    if (abort) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // Control FSM next state plus address/remaining/checksum updates.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    csum_d     = csum_q;
    inflight_d = issue;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          csum_d  = '0;
          addr_d  = base_addr;
          rem_d   = word_count[ADDR_W] ? {1'b1, {ADDR_W{1'b0}}} : word_count;
          state_d = (word_count == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_d == '0 && !inflight_q) state_d = S_DONE;
        else if (cnt_d == '0 && xfer)   state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (xfer) csum_d = csum_q + out_data;
    if (abort) begin
      state_d    = S_IDLE;
      inflight_d = 1'b0;
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      csum_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      csum_q     <= csum_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Buffer storage; contents are only meaningful below cnt_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= sp_readdata;
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign checksum      = csum_q;
  assign sp_chipselect = issue;
  assign sp_address    = issue ? addr_q : '0;
  assign sp_write      = 1'b0;
  assign sp_byteenable = 4'hF;
  assign sp_writedata  = '0;
  assign sp_clken      = 1'b1;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_scratchpad_block_reader.sv
// Bench for scratchpad_block_reader: RAM model, random jobs and backpressure,
// queue-based scoreboard with an independent negedge monitor.
module tb_scratchpad_block_reader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int BUF_D  = 2;
  localparam int DEPTH  = 4096;
  localparam int CW     = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   word_count = '0;
  logic              busy, done;
  logic [DATA_W-1:0] checksum;
  logic [ADDR_W-1:0] sp_address;
  logic              sp_chipselect, sp_write, sp_clken;
  logic [3:0]        sp_byteenable;
  logic [DATA_W-1:0] sp_writedata;
  logic [DATA_W-1:0] sp_readdata = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_csum_q[$];

  int checks = 0;
  int failures = 0;
  int outstanding = 0;
  bit rand_ready = 1'b0;
  logic prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  int fv, dc;
  logic [DATA_W-1:0] sum2;

  scratchpad_block_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_D(BUF_D)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base_addr(base_addr), .word_count(word_count),
    .busy(busy), .done(done), .checksum(checksum),
    .sp_address(sp_address), .sp_chipselect(sp_chipselect), .sp_write(sp_write),
    .sp_byteenable(sp_byteenable), .sp_writedata(sp_writedata), .sp_clken(sp_clken),
    .sp_readdata(sp_readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Scratchpad model: data valid exactly one cycle after an issue, junk otherwise.
  always @(posedge clk) begin
    if (sp_chipselect) sp_readdata <= ram[sp_address];
    else               sp_readdata <= $urandom();
  end

  // Sink ready: always high or a random coin flip per cycle.
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s %s t=%0t", name, what, $time);
  endtask

  task automatic flush_sb();
    exp_q.delete();
    exp_addr_q.delete();
    exp_csum_q.delete();
    outstanding = 0;
  endtask

  // Reference: a job is simply the words at (base + i) mod DEPTH, in order.
  task automatic sb_expect(input logic [ADDR_W-1:0] base, input int count);
    logic [DATA_W-1:0] sum;
    int a;
    sum = '0;
    for (int i = 0; i < count; i++) begin
      a = (int'(base) + i) % DEPTH;
      exp_addr_q.push_back(DATA_W'(a));
      exp_q.push_back(ram[a]);
      sum = sum + ram[a];
    end
    exp_csum_q.push_back(sum);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
    check({tag, "_sp_cs"}, 32'(sp_chipselect), 32'd0);
    check({tag, "_sp_addr"}, 32'(sp_address), 32'd0);
    check({tag, "_sp_write"}, 32'(sp_write), 32'd0);
    check({tag, "_sp_be"}, 32'(sp_byteenable), 32'hF);
    check({tag, "_sp_wdata"}, sp_writedata, 32'd0);
    check({tag, "_sp_clken"}, 32'(sp_clken), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, out_data, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // Monitor: checks issues, stream words, stall stability and done/checksum.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        if (out_valid) check("stall_data_stable", out_data, prev_data);
      end
      if (sp_chipselect) begin
        outstanding++;
        if (exp_addr_q.size() == 0)
          fail_now("unexpected_issue", $sformatf("actual=addr 0x%03h expected=no issue", sp_address));
        else
          check("sp_address", 32'(sp_address), exp_addr_q.pop_front());
      end
      if (out_valid && out_ready) begin
        outstanding--;
        if (exp_q.size() == 0)
          fail_now("unexpected_word", $sformatf("actual=0x%08h expected=no word", out_data));
        else
          check("stream_data", out_data, exp_q.pop_front());
      end
      if (sp_chipselect) check("outstanding_le_buf", 32'(outstanding <= BUF_D), 32'd1);
      if (done) begin
        check("busy_low_at_done", 32'(busy), 32'd0);
        check("drained_at_done", 32'(exp_q.size()), 32'd0);
        if (exp_csum_q.size() == 0)
          fail_now("unexpected_done", "actual=done expected=no done");
        else
          check("checksum", checksum, exp_csum_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // Driver: run one job, optionally poking start again while busy.
  task automatic run_job(input logic [ADDR_W-1:0] base, input int count, input bit extra,
                         output int first_valid, output int done_cyc);
    int budget;
    budget = 40 + count * 16;
    first_valid = -1;
    done_cyc = -1;
    @(posedge clk); #1;
    base_addr  = base;
    word_count = CW'(count);
    start      = 1'b1;
    sb_expect(base, count);
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (cyc == 1 && count != 0) check("busy_after_start", 32'(busy), 32'd1);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk); #1;
      start = extra && (cyc == 2);
      if (start) begin
        base_addr  = ADDR_W'($urandom());
        word_count = CW'($urandom_range(1, 20));
      end
    end
    if (done_cyc < 0) fail_now("job_timeout", $sformatf("actual=no done expected=done within %0d cycles", budget));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA_W'(i);

    // Reset state.
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    // T1: identity RAM, latency, done timing, ignored start while busy.
    rand_ready = 1'b0;
    run_job(12'h010, 4, 1'b1, fv, dc);
    check("t1_first_valid_cycle", 32'(fv), 32'd2);
    check("t1_done_cycle", 32'(dc), 32'd6);
    check("t1_checksum_held", checksum, 32'h46);

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom();

    // T2: address wrap.
    run_job(12'hFFE, 4, 1'b0, fv, dc);
    check("t2_done_cycle", 32'(dc), 32'd6);

    // T3: random backpressure.
    rand_ready = 1'b1;
    run_job(ADDR_W'($urandom()), 8, 1'b1, fv, dc);

    // T4: empty job.
    rand_ready = 1'b0;
    run_job(ADDR_W'($urandom()), 0, 1'b0, fv, dc);
    check("t4_done_cycle", 32'(dc), 32'd1);
    check("t4_checksum", checksum, 32'd0);

    // Random jobs with mixed backpressure.
    repeat (20) begin
      rand_ready = 1'($urandom_range(0, 1));
      run_job(ADDR_W'($urandom()), $urandom_range(1, 24), 1'($urandom_range(0, 1)), fv, dc);
    end

    // Whole RAM in one job.
    rand_ready = 1'b0;
    run_job(ADDR_W'($urandom()), DEPTH, 1'b0, fv, dc);
    check("full_done_cycle", 32'(dc), 32'(DEPTH + 2));

    // start and abort together: abort wins.
    @(posedge clk); #1;
    base_addr = 12'h100; word_count = CW'(5); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("start_abort_busy", 32'(busy), 32'd0);
    end

    // T5: abort three cycles into a 16-word job, then a short job.
    @(posedge clk); #1;
    base_addr = ADDR_W'($urandom()); word_count = CW'(16); start = 1'b1;
    sb_expect(base_addr, 16);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    flush_sb();
    @(negedge clk);
    check("t5_abort_valid", 32'(out_valid), 32'd0);
    check("t5_abort_issue", 32'(sp_chipselect), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_idle_busy", 32'(busy), 32'd0);
      check("t5_idle_valid", 32'(out_valid), 32'd0);
      check("t5_idle_done", 32'(done), 32'd0);
    end
    sum2 = ram[0] + ram[1];
    run_job(12'h000, 2, 1'b0, fv, dc);
    check("t5_second_done_cycle", 32'(dc), 32'd4);
    check("t5_second_checksum", checksum, sum2);

    // T6: asynchronous reset in the middle of a run, then recovery.
    @(posedge clk); #1;
    base_addr = ADDR_W'($urandom()); word_count = CW'(16); start = 1'b1;
    sb_expect(base_addr, 16);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    flush_sb();
    #1;
    check_reset_outs("midrun_reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    rand_ready = 1'b1;
    run_job(ADDR_W'($urandom()), 5, 1'b0, fv, dc);

    repeat (3) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size() + exp_addr_q.size() + exp_csum_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #1000000;
    fail_now("watchdog", "actual=still running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
